pipeline_debug_controller: RTL and testbench
============================================

Name: pipeline_debug_controller

Overview:
Host-facing sequencer for the 5-stage MIPS pipeline. It takes byte commands from a UART receiver and performs four operations:
- loads instruction memory;
- runs the pipeline to HALT, or steps it one clock;
- dumps PC, cycle count and the register bank to the UART transmitter.
It owns the pipeline's global enable and soft reset, and sits between the UART core and the datapath top.

Parameters:
NBITS, 32, datapath word width
RBITS, 5, register address width
BANK_SIZE, 32, registers dumped
MEM_SIZE, 1024, instruction memory size in bytes (word capacity MEM_SIZE/4)
CBITS, 32, cycle counter width

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  received byte valid
o_rx_ready  out  1  controller accepts byte
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  tx byte valid
i_tx_ready  in  1  transmitter accepts byte
o_pipe_en  out  1  pipeline clock enable (all stage regs, PC, memories)
o_pipe_rst  out  1  one-cycle soft reset of pipeline
i_halt  in  1  HALT opcode present in WB
i_pc  in  NBITS  current PC
o_im_we  out  1  instruction memory write strobe
o_im_addr  out  NBITS  byte address of word written
o_im_data  out  NBITS  word written
o_dbg_reg_addr  out  RBITS  register bank debug read address (combinational read)
i_dbg_reg_data  in  NBITS  register bank debug read data
o_busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset values:
  - all outputs 0, except o_rx_ready=1;
  - state IDLE, halted flag 0, cycle counter 0.
- Handshakes:
  - rx byte consumed on the cycle i_rx_valid & o_rx_ready.
  - tx byte transferred on o_tx_valid & i_tx_ready.
  - o_tx_data stays stable and o_tx_valid stays high until transfer.
  - o_rx_ready=0 in every state that does not consume bytes.
- Command codes: 'L'=0x4C, 'R'=0x52, 'S'=0x53, 'D'=0x44.
- Reply codes: ACK=0xA5, ERR=0xEE.
- Multi-byte fields are little-endian.
- States: IDLE, LD_CNT0, LD_CNT1, LD_BYTE, LD_WR, LD_RST, RUN, STEP, DUMP_LATCH, DUMP_SEND, REPLY.
- IDLE: decode the consumed byte.
  - 'L' -> LD_CNT0.
  - 'R' -> RUN.
  - 'S' -> STEP.
  - 'D' -> DUMP_LATCH.
  - Any other byte -> REPLY(ERR).
  - 'R' or 'S' while halted -> REPLY(ERR), with no enable pulse.
- LD_CNT0 / LD_CNT1: capture 16-bit word count N.
  - N=0 -> LD_RST directly.
- LD_BYTE: assemble 4 bytes into one word.
- LD_WR: one cycle.
  - o_im_we=1, o_im_addr=idx*4, o_im_data=word.
  - idx increments.
  - If idx >= MEM_SIZE/4, o_im_we stays 0; the word's bytes are still consumed.
  - After N words -> LD_RST.
- LD_RST: one cycle.
  - o_pipe_rst=1; cycle counter cleared; halted cleared.
  - -> REPLY(ACK).
- RUN:
  - o_pipe_en=1 each cycle while i_halt=0.
  - On the first cycle with i_halt=1: o_pipe_en=0 that cycle, halted set -> REPLY(ACK).
  - If i_halt is already 1 on entry, zero enable cycles are issued.
- STEP:
  - Exactly one cycle of o_pipe_en=1 -> REPLY(ACK).
  - The halted flag is set if i_halt=1 on the cycle after the step.
- DUMP_LATCH: one cycle; snapshot i_pc and the cycle counter.
- DUMP_SEND: send 8 + 4*BANK_SIZE bytes (136 with defaults), in order:
  - PC, 4 bytes;
  - cycle count, 4 bytes;
  - R0..R(BANK_SIZE-1), 4 bytes each.
  - For each register, o_dbg_reg_addr=r and the word is latched when byte 0 of that register is presented.
  - -> IDLE (no trailing ACK).
- REPLY: hold the code until transferred -> IDLE.
- o_pipe_en is 0 in every state except RUN/STEP, so the pipeline is frozen during load and dump.
- Cycle counter:
  - increments on each cycle with o_pipe_en=1;
  - saturates at all-ones (no wrap).
- i_rst mid-operation: immediate return to reset values; partial load words are discarded and nothing is transmitted.
- Simultaneous events:
  - i_halt rising in the same cycle as RUN entry is treated as already halted.
  - rx bytes arriving while busy are held off by o_rx_ready=0, never dropped.

Decomposition:
- Package pipeline_debug_pkg:
  - command codes and ACK/ERR codes;
  - state enum;
  - DUMP_BYTES = 8 + 4*BANK_SIZE.
- Sub-module word_tx_serializer:
  - loads one NBITS word;
  - emits 4 bytes LSB-first over the valid/ready tx handshake;
  - raises done on the last transfer.
  - Used for the PC, cycle-count and register words.

Test Plan:
- 'L',0x02,0x00, then words 0x20010005 and 0xFC000000 -> o_im_we pulses at addr 0 and 4 with those data, then one o_pipe_rst pulse, then tx 0xA5.
- 'R' with i_halt raised after 10 enable cycles -> exactly 10 o_pipe_en cycles, then tx 0xA5; a following 'S' -> tx 0xEE with no enable pulse.
- 'D' after the run, with i_pc=0x00000008 and R1=5 -> 136 bytes:
  - first 08 00 00 00, then 0A 00 00 00;
  - bytes 12..15 = 05 00 00 00;
  - i_tx_ready toggled randomly, with no byte lost or duplicated.
- 'L' with N=0 -> no o_im_we, o_pipe_rst pulse, 0xA5.
- 'L' with N=MEM_SIZE/4+1 -> last word is not written, all bytes are consumed, then 0xA5.
- Unknown byte 0x00 -> tx 0xEE; i_rst asserted mid-load -> all outputs at reset values the next cycle, and the next 'L' loads from addr 0.

Source files
------------

// File: rtl/pipeline_debug_pkg.sv
// Shared command/reply codes, controller state encoding and dump sizing.
// No logic, so no latency of its own.
// No flow control of its own.
package pipeline_debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    localparam int DEF_BANK_SIZE = 32;
    localparam int DUMP_BYTES    = 8 + 4 * DEF_BANK_SIZE;

    // Dump length in bytes for an arbitrary bank size: PC, cycle count, then registers.
    function automatic int dump_bytes(input int bank_size);
        return 8 + 4 * bank_size;
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_CNT0,
        ST_LD_CNT1,
        ST_LD_BYTE,
        ST_LD_WR,
        ST_LD_RST,
        ST_RUN,
        ST_STEP,
        ST_DUMP_LATCH,
        ST_DUMP_SEND,
        ST_REPLY
    } state_t;

endpackage

// File: rtl/pipeline_debug_controller_if.sv
// Byte-stream link between the UART core and the debug controller.
// Pure wiring, no latency.
// rx and tx each use a valid/ready handshake; a byte moves when both are high.
interface pipeline_debug_controller_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/word_tx_serializer.sv
// Sends one loaded word as 4 bytes, least significant byte first.
// First byte is valid the cycle after load; one byte per accepted transfer.
// Holds data and valid while tx_ready is low; done pulses with the last transfer.
module word_tx_serializer #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [NBITS-1:0] word,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done,
    output logic             busy
);
    logic [31:0] shreg;
    logic [1:0]  cnt;
    logic        active;
    logic        xfer;

    assign xfer     = active & tx_ready;
    assign tx_data  = shreg[7:0];
    assign tx_valid = active;
    assign busy     = active;
    assign done     = xfer & (cnt == 2'd3);

    // Load a new word when idle, otherwise shift out one byte per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load && !active) begin
            shreg  <= 32'(word);
            cnt    <= '0;
            active <= 1'b1;
        end else if (xfer) begin
            shreg <= {8'h00, shreg[31:8]};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3)
                active <= 1'b0;
        end
    end
endmodule

// File: rtl/pipeline_debug_controller.sv
// Host command sequencer: loads instruction memory, runs/steps the pipeline, dumps state.
// Commands decode the cycle after the byte is accepted; replies appear the cycle after the operation ends.
// rx_ready is low in every non-consuming state; tx bytes are held until the UART accepts them.
module pipeline_debug_controller
    import pipeline_debug_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int RBITS     = 5,
    parameter int BANK_SIZE = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int CBITS     = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    pipeline_debug_controller_if.slave  uart,
    output logic                        o_pipe_en,
    output logic                        o_pipe_rst,
    input  logic                        i_halt,
    input  logic [NBITS-1:0]            i_pc,
    output logic                        o_im_we,
    output logic [NBITS-1:0]            o_im_addr,
    output logic [NBITS-1:0]            o_im_data,
    output logic [RBITS-1:0]            o_dbg_reg_addr,
    input  logic [NBITS-1:0]            i_dbg_reg_data,
    output logic                        o_busy
);
    localparam int IM_WORDS   = MEM_SIZE / 4;
    localparam int DUMP_WORDS = dump_bytes(BANK_SIZE) / 4;
    localparam int WBITS      = $clog2(DUMP_WORDS + 1);

    state_t            state, state_nx;
    logic [15:0]       cnt_n, idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic              halted, step_chk;
    logic [CBITS-1:0]  cyc, cyc_snap;
    logic [NBITS-1:0]  pc_snap, ser_word;
    logic [7:0]        reply_code, ser_data;
    logic [WBITS-1:0]  widx;
    logic              rx_acc, im_ok, last_word;
    logic              ser_load, ser_valid, ser_done, ser_busy;

    assign rx_acc    = uart.rx_valid & uart.rx_ready;
    assign im_ok     = {16'd0, idx} < 32'(IM_WORDS);
    assign last_word = (idx + 16'd1) == cnt_n;
    assign o_busy    = (state != ST_IDLE);
    // Only drive a register address while a register word is being dumped.
    assign o_dbg_reg_addr = (state == ST_DUMP_SEND && widx >= WBITS'(2))
                          ? RBITS'(widx - WBITS'(2)) : '0;
    assign ser_word = (widx == '0) ? pc_snap
                    : (widx == WBITS'(1)) ? NBITS'(cyc_snap) : i_dbg_reg_data;

    word_tx_serializer #(.NBITS(NBITS)) u_ser (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (ser_load),
        .word     (ser_word),
        .tx_data  (ser_data),
        .tx_valid (ser_valid),
        .tx_ready (uart.tx_ready),
        .done     (ser_done),
        .busy     (ser_busy)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and all handshake/strobe outputs.
    always_comb begin
        state_nx      = state;
        uart.rx_ready = 1'b0;
        uart.tx_valid = 1'b0;
        uart.tx_data  = 8'h00;
        o_pipe_en     = 1'b0;
        o_pipe_rst    = 1'b0;
        o_im_we       = 1'b0;
        o_im_addr     = '0;
        o_im_data     = '0;
        ser_load      = 1'b0;
        case (state)
            ST_IDLE: begin
                uart.rx_ready = 1'b1;
                if (uart.rx_valid) begin
                    case (uart.rx_data)
                        CMD_LOAD: state_nx = ST_LD_CNT0;
                        CMD_RUN:  state_nx = halted ? ST_REPLY : ST_RUN;
                        CMD_STEP: state_nx = halted ? ST_REPLY : ST_STEP;
                        CMD_DUMP: state_nx = ST_DUMP_LATCH;
                        default:  state_nx = ST_REPLY;
                    endcase
                end
            end
            ST_LD_CNT0: begin
                uart.rx_ready = 1'b1;
                if (uart.rx_valid) state_nx = ST_LD_CNT1;
            end
            ST_LD_CNT1: begin
                uart.rx_ready = 1'b1;
                if (uart.rx_valid)
                    state_nx = ({uart.rx_data, cnt_n[7:0]} == 16'd0) ? ST_LD_RST : ST_LD_BYTE;
            end
            ST_LD_BYTE: begin
                uart.rx_ready = 1'b1;
                if (uart.rx_valid && byte_cnt == 2'd3) state_nx = ST_LD_WR;
            end
            ST_LD_WR: begin
                o_im_we   = im_ok;
                o_im_addr = NBITS'({idx, 2'b00});
                o_im_data = NBITS'(word_buf);
                state_nx  = last_word ? ST_LD_RST : ST_LD_BYTE;
            end
            ST_LD_RST: begin
                o_pipe_rst = 1'b1;
                state_nx   = ST_REPLY;
            end
            ST_RUN: begin
                o_pipe_en = !i_halt;
                if (i_halt) state_nx = ST_REPLY;
            end
            ST_STEP: begin
                o_pipe_en = 1'b1;
                state_nx  = ST_REPLY;
            end
            ST_DUMP_LATCH: state_nx = ST_DUMP_SEND;
            ST_DUMP_SEND: begin
                uart.tx_valid = ser_valid;
                uart.tx_data  = ser_data;
                ser_load      = !ser_busy;
                if (ser_done && widx == WBITS'(DUMP_WORDS - 1)) state_nx = ST_IDLE;
            end
            ST_REPLY: begin
                uart.tx_valid = 1'b1;
                uart.tx_data  = reply_code;
                if (uart.tx_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Load assembly, reply selection, halt tracking, cycle counter and dump snapshots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_n      <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            halted     <= 1'b0;
            step_chk   <= 1'b0;
            cyc        <= '0;
            cyc_snap   <= '0;
            pc_snap    <= '0;
            reply_code <= '0;
            widx       <= '0;
        end else begin
            case (state)
                // Default to ERR; every successful path overwrites it with ACK.
                ST_IDLE:    if (rx_acc) reply_code <= RSP_ERR;
                ST_LD_CNT0: if (rx_acc) cnt_n[7:0] <= uart.rx_data;
                ST_LD_CNT1: if (rx_acc) begin
                    cnt_n[15:8] <= uart.rx_data;
                    idx         <= '0;
                    byte_cnt    <= '0;
                end
                ST_LD_BYTE: if (rx_acc) begin
                    word_buf[8*byte_cnt +: 8] <= uart.rx_data;
                    byte_cnt                  <= byte_cnt + 2'd1;
                end
                ST_LD_WR:   idx <= idx + 16'd1;
                ST_LD_RST: begin
                    cyc        <= '0;
                    halted     <= 1'b0;
                    reply_code <= RSP_ACK;
                end
                ST_RUN: if (i_halt) begin
                    halted     <= 1'b1;
                    reply_code <= RSP_ACK;
                end
                ST_STEP:    reply_code <= RSP_ACK;
                ST_DUMP_LATCH: begin
                    pc_snap  <= i_pc;
                    cyc_snap <= cyc;
                    widx     <= '0;
                end
                ST_DUMP_SEND: if (ser_done) widx <= widx + WBITS'(1);
                default: ;
            endcase
            if (o_pipe_en && cyc != '1)
                cyc <= cyc + CBITS'(1);
            // A single step may land on HALT; that shows up in WB one cycle later.
            step_chk <= (state == ST_STEP);
            if (step_chk && i_halt)
                halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Directed bench for the pipeline debug controller with a small pipeline/register-bank model.
// Drives UART bytes through the interface and checks replies, strobes and the dump stream.
// tx_ready is toggled randomly during the dump.
module tb_pipeline_debug_controller;
    import pipeline_debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_en, pipe_rst, im_we, busy;
    logic        i_halt = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] im_addr, im_data, dbg_data;
    logic [4:0]  dbg_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int halt_after = -1;
    logic [63:0] wq[$];

    pipeline_debug_controller_if uif();

    pipeline_debug_controller dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .uart           (uif),
        .o_pipe_en      (pipe_en),
        .o_pipe_rst     (pipe_rst),
        .i_halt         (i_halt),
        .i_pc           (pc),
        .o_im_we        (im_we),
        .o_im_addr      (im_addr),
        .o_im_data      (im_data),
        .o_dbg_reg_addr (dbg_addr),
        .i_dbg_reg_data (dbg_data),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_model(input logic [4:0] r);
        return (r == 5'd1) ? 32'h5 : (32'hC0DE0000 | 32'(r));
    endfunction

    assign dbg_data = reg_model(dbg_addr);

    // Observe strobes mid-cycle.
    always @(negedge clk) begin
        if (im_we)    wq.push_back({im_addr, im_data});
        if (pipe_rst) rst_cnt++;
        if (pipe_en)  en_cnt++;
    end

    // Pipeline model: HALT reaches WB once the requested number of enable cycles has elapsed.
    always @(posedge clk) begin
        #1;
        i_halt = (halt_after >= 0) && (en_cnt >= halt_after);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        uif.rx_data  = b;
        uif.rx_valid = 1'b1;
        while (!uif.rx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq("rx_accept_timeout", 64'(t >= 400), 64'd0);
        @(posedge clk);
        #1 uif.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input bit rnd);
        int t;
        bit got;
        bit hold_v;
        logic [7:0] held;
        t = 0; got = 0; hold_v = 0; held = 8'h00; b = 8'h00;
        while (!got && t < 400) begin
            @(negedge clk);
            if (hold_v) check_eq("tx_hold", {55'd0, uif.tx_valid, uif.tx_data}, {55'd0, 1'b1, held});
            uif.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (uif.tx_valid && uif.tx_ready) begin
                got = 1;
                b = uif.tx_data;
            end else begin
                hold_v = uif.tx_valid;
                held   = uif.tx_data;
                t++;
            end
        end
        check_eq("tx_wait_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1 uif.tx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {56'd0, uif.rx_ready, busy, uif.tx_valid, pipe_en, pipe_rst, im_we, 2'b00},
                      {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        check_eq({tag, "_bus"}, {uif.tx_data, dbg_addr, im_addr[15:0], im_data[15:0]}, 64'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_dump [DUMP_BYTES];
        int base_w, base_r, base_e;

        uif.rx_data  = 8'h00;
        uif.rx_valid = 1'b0;
        uif.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Two-word load.
        base_w = wq.size(); base_r = rst_cnt;
        send_byte(CMD_LOAD); send_byte(8'h02); send_byte(8'h00);
        send_word(32'h20010005); send_word(32'hFC000000);
        recv_byte(b, 0);
        check_eq("load2_reply", b, RSP_ACK);
        check_eq("load2_nwr", wq.size() - base_w, 2);
        check_eq("load2_w0", wq[base_w], {32'd0, 32'h20010005});
        check_eq("load2_w1", wq[base_w+1], {32'd4, 32'hFC000000});
        check_eq("load2_rst", rst_cnt - base_r, 1);
        check_eq("load2_no_en", en_cnt, 0);

        // Run until HALT after 10 enable cycles, then a step while halted.
        halt_after = en_cnt + 10;
        send_byte(CMD_RUN);
        recv_byte(b, 0);
        check_eq("run_reply", b, RSP_ACK);
        check_eq("run_en_cycles", en_cnt, 10);
        send_byte(CMD_STEP);
        recv_byte(b, 0);
        check_eq("step_halted_reply", b, RSP_ERR);
        check_eq("step_halted_en", en_cnt, 10);

        // Dump with random tx backpressure.
        pc = 32'h00000008;
        for (int i = 0; i < 4; i++) begin
            exp_dump[i]     = pc[8*i +: 8];
            exp_dump[4 + i] = 8'(32'd10 >> (8*i));
        end
        for (int r = 0; r < DEF_BANK_SIZE; r++)
            for (int i = 0; i < 4; i++)
                exp_dump[8 + 4*r + i] = 8'(reg_model(5'(r)) >> (8*i));
        send_byte(CMD_DUMP);
        for (int i = 0; i < DUMP_BYTES; i++) begin
            recv_byte(b, 1);
            check_eq($sformatf("dump_byte%0d", i), b, exp_dump[i]);
        end
        repeat (3) @(negedge clk);
        check_eq("dump_no_trailer", {62'd0, uif.tx_valid, busy}, 64'd0);

        // Zero-length load.
        base_w = wq.size(); base_r = rst_cnt; base_e = en_cnt;
        send_byte(CMD_LOAD); send_byte(8'h00); send_byte(8'h00);
        recv_byte(b, 0);
        check_eq("load0_reply", b, RSP_ACK);
        check_eq("load0_nwr", wq.size() - base_w, 0);
        check_eq("load0_rst", rst_cnt - base_r, 1);
        check_eq("load0_no_en", en_cnt - base_e, 0);

        // Unknown command.
        send_byte(8'h00);
        recv_byte(b, 0);
        check_eq("unknown_reply", b, RSP_ERR);

        // Overlong load: 257 words into a 256-word memory.
        base_w = wq.size();
        send_byte(CMD_LOAD); send_byte(8'h01); send_byte(8'h01);
        for (int w = 0; w < 257; w++) send_word(32'h5A000000 + 32'(w));
        recv_byte(b, 0);
        check_eq("loadovf_reply", b, RSP_ACK);
        check_eq("loadovf_nwr", wq.size() - base_w, 256);
        check_eq("loadovf_first", wq[base_w], {32'd0, 32'h5A000000});
        check_eq("loadovf_last", wq[base_w+255], {32'd1020, 32'h5A0000FF});
        @(negedge clk);
        check_eq("loadovf_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a load, then a fresh load.
        send_byte(CMD_LOAD); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        base_w = wq.size();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        send_byte(CMD_LOAD); send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEADBEEF);
        recv_byte(b, 0);
        check_eq("postrst_reply", b, RSP_ACK);
        check_eq("postrst_nwr", wq.size() - base_w, 1);
        check_eq("postrst_w0", wq[base_w], {32'd0, 32'hDEADBEEF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
